// File: rtl/fabric_ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and
// the word-count arithmetic that splits the chain into host-sized words.
package fabric_ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits of the final word that actually reach the chain.
    function automatic int calc_last_bits(input int chain_len, input int word_w);
        return chain_len - (calc_nwords(chain_len, word_w) - 1) * word_w;
    endfunction

endpackage

// File: rtl/fabric_ccff_loader_if.sv
// Host-side bitstream word handshake into the loader.
interface fabric_ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/fabric_ccff_word_ser.sv
// Word serializer: holds the word being shifted out LSB first and flags
// the cycle in which its last used bit is on the output.
module fabric_ccff_word_ser #(
    parameter int WORD_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [WORD_W-1:0]            load_word,
    input  logic [$clog2(WORD_W+1)-1:0]  load_bits,
    input  logic                         shift,
    output logic                         head,
    output logic                         word_last
);
    localparam int BW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     bit_idx;
    logic [BW-1:0]     nbits;

    // A load on the same edge as the last shift replaces the word outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_idx <= '0;
            nbits   <= BW'(WORD_W);
        end else if (load) begin
            sreg    <= load_word;
            bit_idx <= '0;
            nbits   <= load_bits;
        end else if (shift) begin
            sreg    <= {1'b0, sreg[WORD_W-1:1]};
            bit_idx <= bit_idx + BW'(1);
        end
    end

    assign head      = sreg[0];
    assign word_last = (bit_idx == nbits - BW'(1));

endmodule

// File: rtl/fabric_ccff_loader.sv
// Streams host bitstream words into a serial configuration flip-flop chain,
// double-buffering one word so back-to-back words shift without a bubble.
module fabric_ccff_loader
    import fabric_ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 20
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    fabric_ccff_loader_if.slave            cfg,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] tail_ones
);
    localparam int NWORDS    = calc_nwords(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = calc_last_bits(CHAIN_LEN, WORD_W);
    localparam int CW        = $clog2(CHAIN_LEN + 1);
    localparam int AW        = $clog2(NWORDS + 1);
    localparam int BW        = $clog2(WORD_W + 1);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] hold;
    logic              hold_full;
    logic              hold_last;
    logic [AW-1:0]     words_accepted;
    logic [CW-1:0]     bit_cnt;

    logic              xfer;
    logic              start_load;
    logic              load_sreg;
    logic              shift;
    logic              ser_head;
    logic              word_last;
    logic [BW-1:0]     load_bits;

    assign cfg.cfg_ready = ((state == FILL) || (state == SHIFT)) && !hold_full
                           && (words_accepted < AW'(NWORDS));
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign load_bits     = hold_last ? BW'(LAST_BITS) : BW'(WORD_W);
    assign ccff_head     = (state == SHIFT) && ser_head;

    always_comb begin
        state_next    = state;
        start_load    = 1'b0;
        load_sreg     = 1'b0;
        shift         = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_load = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (hold_full) begin
                    load_sreg  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift         = 1'b1;
                ccff_shift_en = 1'b1;
                if (bit_cnt == CW'(CHAIN_LEN - 1)) begin
                    state_next = DONE;
                end else if (word_last) begin
                    if (hold_full) load_sreg  = 1'b1;
                    else           state_next = FILL;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // hold can only be written while empty, so a buffered word is never lost.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state          <= IDLE;
            hold           <= '0;
            hold_full      <= 1'b0;
            hold_last      <= 1'b0;
            words_accepted <= '0;
            bit_cnt        <= '0;
            tail_ones      <= '0;
        end else begin
            state <= state_next;
            if (start_load) begin
                hold_full      <= 1'b0;
                words_accepted <= '0;
                bit_cnt        <= '0;
                tail_ones      <= '0;
            end else begin
                if (xfer) begin
                    hold           <= cfg.cfg_data;
                    hold_full      <= 1'b1;
                    hold_last      <= (words_accepted == AW'(NWORDS - 1));
                    words_accepted <= words_accepted + AW'(1);
                end else if (load_sreg) begin
                    hold_full <= 1'b0;
                end
                if (shift) begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (ccff_tail) tail_ones <= tail_ones + CW'(1);
                end
            end
        end
    end

    fabric_ccff_word_ser #(.WORD_W(WORD_W)) u_word_ser (
        .clk       (prog_clk),
        .rst       (pReset),
        .load      (load_sreg),
        .load_word (hold),
        .load_bits (load_bits),
        .shift     (shift),
        .head      (ser_head),
        .word_last (word_last)
    );

endmodule

// File: doc/fabric_ccff_loader.md
FABRIC_CCFF_LOADER -- requirements
Module: fabric_ccff_loader

Interface
REQ-001 Parameter: WORD_W, 8, width of each bitstream word accepted from the host.
REQ-002 Parameter: CHAIN_LEN, 20, number of configuration flip-flops in the downstream ccff chain.
REQ-003 Port: prog_clk  input  1  the single clock, which is also the configuration chain clock.
REQ-004 Port: pReset  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  single-cycle request to begin a chain load; sampled only in IDLE.
REQ-006 Port: cfg_data  input  WORD_W  bitstream word; bit 0 is shifted first.
REQ-007 Port: cfg_valid  input  1  cfg_data is valid.
REQ-008 Port: cfg_ready  output  1  loader accepts cfg_data this cycle (transfer = cfg_valid & cfg_ready).
REQ-009 Port: ccff_head  output  1  serial data into the chain head.
REQ-010 Port: ccff_shift_en  output  1  chain flip-flops capture ccff_head on this prog_clk edge (clock-enable/gate).
REQ-011 Port: ccff_tail  input  1  serial data from the chain tail (old contents leaving).
REQ-012 Port: busy  output  1  a load is in progress.
REQ-013 Port: done  output  1  one-cycle pulse when the last chain bit has been shifted.
REQ-014 Port: tail_ones  output  $clog2(CHAIN_LEN+1)  count of 1s observed on ccff_tail during the last load.

Function
REQ-015 FSM states: IDLE, FILL, SHIFT, DONE.
REQ-016 IDLE: on start=1 -> FILL, and both bit_cnt and tail_ones clear to 0.
REQ-017 NWORDS = ceil(CHAIN_LEN/WORD_W); exactly NWORDS words are accepted per load, and no more.
REQ-018 The datapath has a shift register (sreg) and a one-word holding register (hold).
REQ-019 cfg_ready = 1 iff state is FILL or SHIFT, hold is empty, and words_accepted < NWORDS.
REQ-020 In FILL, once hold is full, hold moves to sreg and the FSM goes to SHIFT on the next cycle.
REQ-021 In SHIFT, each cycle: ccff_head=sreg[0], ccff_shift_en=1, sreg shifts right by 1, bit_cnt increments by 1, and tail_ones increments if ccff_tail=1.
REQ-022 When the current word's last used bit shifts and hold is full, hold loads into sreg in the same edge, so shifting continues without a bubble.
REQ-023 When the current word is exhausted, hold is empty and bit_cnt<CHAIN_LEN, the FSM goes to FILL and ccff_shift_en=0 until a word arrives.
REQ-024 The final word uses only CHAIN_LEN-(NWORDS-1)*WORD_W bits; its upper bits are never driven onto ccff_head.
REQ-025 When bit_cnt reaches CHAIN_LEN, the FSM goes to DONE; done=1 for exactly one cycle, then IDLE.
REQ-026 ccff_shift_en=0 in IDLE, FILL and DONE; the chain never advances without a valid bit.
REQ-027 busy=1 in FILL, SHIFT and DONE.
REQ-028 A start asserted outside IDLE is ignored; start coincident with DONE is also ignored.
REQ-029 tail_ones holds its value from DONE until the next accepted start.
REQ-030 If cfg_valid drops mid-load, the loader stalls indefinitely in FILL; there is no timeout.
REQ-031 A word accepted into hold is never overwritten before it has been consumed.

Reset
REQ-032 pReset=1 at a prog_clk edge forces: IDLE, hold empty, bit_cnt=0, words_accepted=0, tail_ones=0, sreg=0.
REQ-033 During reset and on the cycle after it: cfg_ready=0, ccff_shift_en=0, ccff_head=0, busy=0, done=0.
REQ-034 Reset mid-load abandons the load; the chain keeps a partial shift, and software must restart.

Structure
REQ-035 A shared package holds the state enum (IDLE/FILL/SHIFT/DONE) and the NWORDS/last-word-width derivation functions.
REQ-036 One sub-module is natural: fabric_ccff_word_ser (sreg plus per-word bit index, producing a word-exhausted flag); everything else stays in the top.

Verification
REQ-037 CHAIN_LEN=20, WORD_W=8, words 0xA5,0x3C,0xF9 streamed back-to-back -> 20 consecutive ccff_shift_en cycles, head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1; done one cycle later.
REQ-038 Same words with 3 idle cycles before word 2 -> ccff_shift_en low exactly 3+ cycles after bit 8, total enabled cycles = 20, data unchanged.
REQ-039 ccff_tail tied 1 for the whole load -> tail_ones=20 after done; ccff_tail alternating 1/0 -> tail_ones=10.
REQ-040 pReset asserted after 12 bits shifted -> next cycle busy=0, ccff_shift_en=0, tail_ones=0; a fresh start reloads the full 20 bits.
REQ-041 start pulsed during SHIFT and on the DONE cycle -> no effect; a 4th word offered after 3 accepted -> cfg_ready stays 0.
REQ-042 Last word 0xFF -> only 4 ones are shifted for that word, with no ccff_shift_en beyond bit 20.
